// File: rtl/shift_register_sequencer_if.sv
// Command, load-data and shift-register control bundle
// for the shift register sequencer.
interface shift_register_sequencer_if #(
    parameter int W = 128
);
    logic         io_cmd_valid;
    logic         io_cmd_ready;
    logic [1:0]   io_cmd_op;
    logic [3:0]   io_cmd_count;
    logic         io_cmd_tap;
    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_data;
    logic         io_abort;
    logic         io_sr_enable;
    logic         io_sr_rev;
    logic         io_sr_cyc;
    logic         io_sr_tap;
    logic [W-1:0] io_sr_input;
    logic         io_busy;
    logic         io_done;
    logic [3:0]   io_steps;

    modport slave (
        input  io_cmd_valid, io_cmd_op, io_cmd_count, io_cmd_tap,
        input  io_in_valid, io_in_data, io_abort,
        output io_cmd_ready, io_in_ready,
        output io_sr_enable, io_sr_rev, io_sr_cyc, io_sr_tap,
        output io_sr_input, io_busy, io_done, io_steps
    );

    modport master (
        output io_cmd_valid, io_cmd_op, io_cmd_count, io_cmd_tap,
        output io_in_valid, io_in_data, io_abort,
        input  io_cmd_ready, io_in_ready,
        input  io_sr_enable, io_sr_rev, io_sr_cyc, io_sr_tap,
        input  io_sr_input, io_busy, io_done, io_steps
    );
endinterface

// File: rtl/shift_register_sequencer.sv
// Sequences LOAD / rotate / shift commands onto a DEPTH-stage
// shift register, one enable per step.
module shift_register_sequencer #(
    parameter int W     = 128,
    parameter int DEPTH = 15
) (
    input logic                         clock,
    input logic                         reset_n,
    shift_register_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_FWD  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd3;
    localparam logic [3:0] MAXC    = 4'(DEPTH);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_op;
    logic [3:0]   r_count;
    logic         r_tap;
    logic [3:0]   r_steps;
    logic [3:0]   w_steps_nxt;
    logic [3:0]   w_steps_inc;
    logic [3:0]   w_count_clamp;
    logic         w_accept;

    logic         w_cmd_ready;
    logic         w_in_ready;
    logic         w_en;
    logic         w_rev;
    logic         w_cyc;
    logic         w_tap;
    logic         w_done;
    logic [W-1:0] w_sr_input;

    assign w_count_clamp = (bus.io_cmd_count > MAXC) ? MAXC
                                                     : bus.io_cmd_count;
    assign w_accept    = (r_state == S_IDLE) && bus.io_cmd_valid;
    assign w_steps_inc = r_steps + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_count <= 4'd0;
            r_tap   <= 1'b0;
            r_steps <= 4'd0;
        end else begin
            r_state <= w_next;
            r_steps <= w_steps_nxt;
            if (w_accept) begin
                r_op    <= bus.io_cmd_op;
                r_count <= w_count_clamp;
                r_tap   <= bus.io_cmd_tap;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_steps_nxt = r_steps;
        w_cmd_ready = 1'b0;
        w_in_ready  = 1'b0;
        w_en        = 1'b0;
        w_rev       = 1'b0;
        w_cyc       = 1'b0;
        w_tap       = 1'b0;
        w_done      = 1'b0;
        w_sr_input  = '0;
        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.io_cmd_valid) begin
                    w_steps_nxt = 4'd0;
                    if (w_count_clamp == 4'd0)
                        w_next = S_DONE;
                    else if (bus.io_cmd_op == OP_LOAD)
                        w_next = S_LOAD;
                    else
                        w_next = S_RUN;
                end
            end
            S_LOAD: begin
                w_tap      = r_tap;
                w_sr_input = bus.io_in_data;
                // abort wins over a completing handshake
                if (bus.io_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_in_ready = 1'b1;
                    w_en       = bus.io_in_valid;
                    if (bus.io_in_valid) begin
                        w_steps_nxt = w_steps_inc;
                        if (w_steps_inc == r_count)
                            w_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                w_tap = r_tap;
                w_rev = (r_op != OP_FWD);
                w_cyc = (r_op != OP_SHR);
                if (bus.io_abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_en        = 1'b1;
                    w_steps_nxt = w_steps_inc;
                    if (w_steps_inc == r_count)
                        w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_tap  = r_tap;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.io_cmd_ready = w_cmd_ready;
    assign bus.io_in_ready  = w_in_ready;
    assign bus.io_sr_enable = w_en;
    assign bus.io_sr_rev    = w_rev;
    assign bus.io_sr_cyc    = w_cyc;
    assign bus.io_sr_tap    = w_tap;
    assign bus.io_sr_input  = w_sr_input;
    assign bus.io_busy      = (r_state != S_IDLE);
    assign bus.io_done      = w_done;
    assign bus.io_steps     = r_steps;
endmodule
